dense_layer_folded: RTL and testbench

Time-multiplexed fully-connected layer for the fixed-point inference pipeline. It is the parametrised successor to the fully parallel dense layer, with three additions:
- NUM_PARALLEL MAC lanes are reused over groups of neurons.
- Weights and biases are loaded at runtime.
- Activation is selectable, with saturation.

It sits between layers and uses the same inputs_ready/outputs_ready handshake as the other layer blocks.

---
 rtl/dense_layer_folded.sv | 264 ++++++++++++++++++++++++++
 tb/tb_dense_layer_folded.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dense_layer_folded.sv
// -----------------------------------------------------------------------------
// dense_layer_folded
//
// Time-multiplexed fully-connected layer for the fixed-point inference
// pipeline. NUM_PARALLEL MAC lanes are reused over G = NUM_NEURONS/NUM_PARALLEL
// groups of neurons. Weights and biases live in a runtime-writable coefficient
// memory. Each result is scaled back to the Q(INTEGER_WIDTH.FRACTION_WIDTH)
// format, saturated, then passed through the selected activation.
//
// NUM_NEURONS must be a multiple of NUM_PARALLEL.
//
// Ports:
//   clock          in   rising-edge system clock
//   reset          in   asynchronous active-low reset
//   inputs_ready   in   start request, sampled only when not busy
//   inputs         in   NUM_INPUTS signed activations, captured on start
//   weight_write   in   coefficient write strobe (IDLE/DONE only)
//   weight_neuron  in   target neuron of the write
//   weight_index   in   0..NUM_INPUTS-1 selects a weight, NUM_INPUTS the bias
//   weight_data    in   signed coefficient value
//   busy           out  high while the layer is computing
//   outputs_ready  out  level, results valid until the next accepted start
//   outputs        out  NUM_NEURONS signed results
// -----------------------------------------------------------------------------
package dense_layer_folded_pkg;
   typedef enum logic {
      NONE = 1'b0,
      RELU = 1'b1
   } activation_type;
endpackage

module dense_layer_folded
   import dense_layer_folded_pkg::*;
#(
   parameter int             NUM_INPUTS     = 16,
   parameter int             NUM_NEURONS    = 16,
   parameter int             NUM_PARALLEL   = 4,
   parameter activation_type ACTIVATION     = RELU,
   parameter int             INTEGER_WIDTH  = 8,
   parameter int             FRACTION_WIDTH = 8,
   localparam int            W              = INTEGER_WIDTH + FRACTION_WIDTH,
   localparam int            NW             = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
   localparam int            IW             = $clog2(NUM_INPUTS + 1)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                inputs_ready,
   input  logic signed [W-1:0] inputs [NUM_INPUTS],
   input  logic                weight_write,
   input  logic [NW-1:0]       weight_neuron,
   input  logic [IW-1:0]       weight_index,
   input  logic signed [W-1:0] weight_data,
   output logic                busy,
   output logic                outputs_ready,
   output logic signed [W-1:0] outputs [NUM_NEURONS]
);

   // ---------------------------------------------------------------------------
   // Derived sizes
   // ---------------------------------------------------------------------------
   localparam int G  = NUM_NEURONS / NUM_PARALLEL;
   localparam int GW = (G > 1) ? $clog2(G) : 1;
   localparam int II = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
   localparam int PW = 2 * W;                 // full product width
   localparam int AW = 2 * W + IW;            // accumulator cannot overflow

   localparam logic [GW-1:0] G_LAST = GW'(G - 1);
   localparam logic [II-1:0] I_LAST = II'(NUM_INPUTS - 1);

   // Saturation bounds expressed at accumulator width for signed compares.
   localparam logic signed [AW-1:0] SAT_MAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [AW-1:0] SAT_MIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MAC   = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t               state;
   state_t               state_next;
   logic [GW-1:0]        group;
   logic [II-1:0]        in_index;
   logic signed [W-1:0]  captured [NUM_INPUTS];
   logic signed [W-1:0]  weights  [NUM_NEURONS][NUM_INPUTS];
   logic signed [W-1:0]  biases   [NUM_NEURONS];
   logic signed [AW-1:0] acc      [NUM_PARALLEL];
   logic signed [W-1:0]  lane_result [NUM_PARALLEL];

   logic idle;
   logic start;
   logic coef_write;

   assign idle  = (state == IDLE) || (state == DONE);
   assign start = idle && inputs_ready;
   // A write in the same cycle as an accepted start is dropped so the run
   // sees a coherent coefficient set.
   assign coef_write = weight_write && idle && !inputs_ready;

   // ---------------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------------
   function automatic logic [NW-1:0] neuron_of(input logic [GW-1:0] g, input int lane);
      return NW'(int'(g) * NUM_PARALLEL + lane);
   endfunction

   // Bias is pre-aligned so it adds directly to the Q(2*FRACTION_WIDTH) products.
   function automatic logic signed [AW-1:0] align_bias(input logic signed [W-1:0] b);
      return AW'(b) <<< FRACTION_WIDTH;
   endfunction

   function automatic logic signed [W-1:0] finish_value(input logic signed [AW-1:0] a);
      logic signed [AW-1:0] shifted;
      logic signed [W-1:0]  value;
      // Arithmetic shift rounds toward -inf.
      shifted = a >>> FRACTION_WIDTH;
      if (shifted > SAT_MAX) begin
         value = SAT_MAX[W-1:0];
      end else if (shifted < SAT_MIN) begin
         value = SAT_MIN[W-1:0];
      end else begin
         value = shifted[W-1:0];
      end
      if (ACTIVATION == RELU && value[W-1]) begin
         value = '0;
      end
      return value;
   endfunction

   // ---------------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------------
   // NOTE: sequential state is updated with <= so every register samples the
   // values from before the edge, independent of block ordering.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: every output of this block gets a default first, so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      state_next    = state;
      busy          = 1'b0;
      outputs_ready = 1'b0;
      case (state)
         IDLE: begin
            if (inputs_ready) state_next = MAC;
         end
         MAC: begin
            busy = 1'b1;
            if (in_index == I_LAST) state_next = WRITE;
         end
         WRITE: begin
            busy       = 1'b1;
            state_next = (group == G_LAST) ? DONE : MAC;
         end
         DONE: begin
            outputs_ready = 1'b1;
            if (inputs_ready) state_next = MAC;
         end
         default: state_next = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Sequencing counters and input capture
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         group    <= '0;
         in_index <= '0;
         for (int i = 0; i < NUM_INPUTS; i++) captured[i] <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (inputs_ready) begin
                  group    <= '0;
                  in_index <= '0;
                  captured <= inputs;
               end
            end
            MAC: begin
               in_index <= (in_index == I_LAST) ? '0 : in_index + 1'b1;
            end
            WRITE: begin
               if (group != G_LAST) group <= group + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Coefficient memory
   // ---------------------------------------------------------------------------
   // NOTE: this memory is register-based and must read back as zero after
   // reset, so it sits in the reset branch like any other state.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int n = 0; n < NUM_NEURONS; n++) begin
            biases[n] <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) weights[n][i] <= '0;
         end
      end else if (coef_write && int'(weight_neuron) < NUM_NEURONS) begin
         if (int'(weight_index) < NUM_INPUTS) begin
            weights[weight_neuron][weight_index[II-1:0]] <= weight_data;
         end else if (int'(weight_index) == NUM_INPUTS) begin
            biases[weight_neuron] <= weight_data;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // MAC lanes
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int lane = 0; lane < NUM_PARALLEL; lane++) acc[lane] <= '0;
      end else begin
         for (int lane = 0; lane < NUM_PARALLEL; lane++) begin
            if (start) begin
               acc[lane] <= align_bias(biases[neuron_of('0, lane)]);
            end else if (state == MAC) begin
               acc[lane] <= acc[lane]
                          + AW'(PW'(captured[in_index])
                              * PW'(weights[neuron_of(group, lane)][in_index]));
            end else if (state == WRITE && group != G_LAST) begin
               // Preload the next group's biases while its results are stored.
               acc[lane] <= align_bias(biases[neuron_of(group + 1'b1, lane)]);
            end
         end
      end
   end

   always_comb begin
      for (int lane = 0; lane < NUM_PARALLEL; lane++) lane_result[lane] = '0;
      for (int lane = 0; lane < NUM_PARALLEL; lane++) begin
         lane_result[lane] = finish_value(acc[lane]);
      end
   end

   // ---------------------------------------------------------------------------
   // Result registers: only the current group's neurons are rewritten, the
   // rest hold their previous values.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int n = 0; n < NUM_NEURONS; n++) outputs[n] <= '0;
      end else if (state == WRITE) begin
         for (int lane = 0; lane < NUM_PARALLEL; lane++) begin
            outputs[neuron_of(group, lane)] <= lane_result[lane];
         end
      end
   end

endmodule

// File: tb/tb_dense_layer_folded.sv
// -----------------------------------------------------------------------------
// tb_dense_layer_folded
//
// Directed bench for dense_layer_folded. Two instances, one per activation
// type, share all stimulus so every run checks NONE and RELU side by side.
// -----------------------------------------------------------------------------
module tb_dense_layer_folded;
   import dense_layer_folded_pkg::*;

   localparam int NI = 16;
   localparam int NN = 16;
   localparam int W  = 16;

   logic                clock        = 1'b0;
   logic                reset        = 1'b0;
   logic                inputs_ready = 1'b0;
   logic                weight_write = 1'b0;
   logic [3:0]          weight_neuron = '0;
   logic [4:0]          weight_index  = '0;
   logic signed [W-1:0] weight_data   = '0;
   logic signed [W-1:0] inputs [NI];

   logic                busy_none, busy_relu, rdy_none, rdy_relu;
   logic signed [W-1:0] out_none [NN];
   logic signed [W-1:0] out_relu [NN];

   logic [15:0] exp_none [NN];
   logic [15:0] exp_relu [NN];

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   dense_layer_folded #(.ACTIVATION(NONE)) dut_none (
      .clock(clock), .reset(reset), .inputs_ready(inputs_ready), .inputs(inputs),
      .weight_write(weight_write), .weight_neuron(weight_neuron),
      .weight_index(weight_index), .weight_data(weight_data),
      .busy(busy_none), .outputs_ready(rdy_none), .outputs(out_none)
   );

   dense_layer_folded #(.ACTIVATION(RELU)) dut_relu (
      .clock(clock), .reset(reset), .inputs_ready(inputs_ready), .inputs(inputs),
      .weight_write(weight_write), .weight_neuron(weight_neuron),
      .weight_index(weight_index), .weight_data(weight_data),
      .busy(busy_relu), .outputs_ready(rdy_relu), .outputs(out_relu)
   );

   task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic write_coef(input int n, input int idx, input logic [15:0] data);
      weight_neuron = 4'(n);
      weight_index  = 5'(idx);
      weight_data   = data;
      weight_write  = 1'b1;
      tick();
      weight_write  = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   task automatic set_all(input logic [15:0] v);
      for (int i = 0; i < NI; i++) inputs[i] = v;
   endtask

   task automatic set_expect(input logic [15:0] vn, input logic [15:0] vr);
      for (int n = 0; n < NN; n++) begin
         exp_none[n] = vn;
         exp_relu[n] = vr;
      end
   endtask

   task automatic check_outs(input string tag);
      for (int n = 0; n < NN; n++) begin
         check($sformatf("%s_none%0d", tag, n), out_none[n], exp_none[n]);
         check($sformatf("%s_relu%0d", tag, n), out_relu[n], exp_relu[n]);
      end
   endtask

   // Start a run, optionally pulse inputs_ready or issue a weight write
   // (w[1][1]=1.0) at a given cycle while busy, and wait for outputs_ready.
   task automatic run_wait(input string tag, input int pulse_at, input int write_at);
      int cycles = 0;
      inputs_ready = 1'b1;
      tick();
      inputs_ready = 1'b0;
      weight_write = 1'b0;
      check({tag, "_busy"}, 16'({busy_none, busy_relu, rdy_none, rdy_relu}), 16'hC);
      while (!rdy_none && cycles < 200) begin
         inputs_ready = (cycles == pulse_at);
         if (cycles == write_at) begin
            weight_neuron = 4'd1;
            weight_index  = 5'd1;
            weight_data   = 16'h0100;
            weight_write  = 1'b1;
         end
         tick();
         cycles++;
         inputs_ready = 1'b0;
         weight_write = 1'b0;
      end
      check({tag, "_latency"}, 16'(cycles), 16'd68);
      check({tag, "_flags"}, 16'({busy_none, busy_relu, rdy_none, rdy_relu}), 16'h3);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      set_all(16'h0000);

      // Reset state
      tick();
      tick();
      check("reset_flags", 16'({busy_none, busy_relu, rdy_none, rdy_relu}), 16'h0);
      set_expect(16'h0000, 16'h0000);
      check_outs("reset");
      reset = 1'b1;

      // 1. No coefficients loaded; a start pulse while busy is ignored.
      set_all(16'h0100);
      run_wait("t1", 20, -1);
      set_expect(16'h0000, 16'h0000);
      check_outs("t1");

      // 2. Identity weights, ramp inputs.
      do_reset();
      for (int n = 0; n < NN; n++) write_coef(n, n, 16'h0100);
      for (int i = 0; i < NI; i++) inputs[i] = 16'(i * 16'h0080);
      run_wait("t2", -1, -1);
      for (int n = 0; n < NN; n++) begin
         exp_none[n] = 16'(n * 16'h0080);
         exp_relu[n] = 16'(n * 16'h0080);
      end
      check_outs("t2");
      set_all(16'h1234);
      tick();
      tick();
      tick();
      check_outs("t2_hold");
      check("t2_hold_ready", 16'({rdy_none, rdy_relu}), 16'h3);

      // 3. Negative sum, bias-only neuron, write colliding with start dropped.
      do_reset();
      for (int i = 0; i < NI; i++) write_coef(0, i, 16'hFF00);
      write_coef(3, NI, 16'h0280);
      set_all(16'h0100);
      weight_neuron = 4'd5;
      weight_index  = 5'd16;
      weight_data   = 16'h0100;
      weight_write  = 1'b1;
      run_wait("t3", -1, -1);
      set_expect(16'h0000, 16'h0000);
      exp_none[0] = 16'hF000;
      exp_relu[0] = 16'h0000;
      exp_none[3] = 16'h0280;
      exp_relu[3] = 16'h0280;
      check_outs("t3");

      // 4. Saturation both ways.
      do_reset();
      for (int n = 0; n < NN; n++)
         for (int i = 0; i < NI; i++) write_coef(n, i, 16'h7F00);
      set_all(16'h7F00);
      run_wait("t4a", -1, -1);
      set_expect(16'h7FFF, 16'h7FFF);
      check_outs("t4a");
      set_all(16'h8100);
      run_wait("t4b", -1, -1);
      set_expect(16'h8000, 16'h0000);
      check_outs("t4b");

      // 5. Truncation toward -inf.
      do_reset();
      write_coef(0, 0, 16'h0001);
      set_all(16'h0000);
      inputs[0] = 16'h0001;
      run_wait("t5a", -1, -1);
      set_expect(16'h0000, 16'h0000);
      check_outs("t5a");
      inputs[0] = 16'hFFFF;
      run_wait("t5b", -1, -1);
      exp_none[0] = 16'hFFFF;
      check_outs("t5b");

      // 6. Write while busy ignored, out-of-range index ignored, group hold,
      //    reset mid-run, clean restart.
      do_reset();
      write_coef(0, 0, 16'h0100);
      write_coef(2, 17, 16'h0100);
      set_all(16'h0100);
      run_wait("t6a", -1, 5);
      set_expect(16'h0000, 16'h0000);
      exp_none[0] = 16'h0100;
      exp_relu[0] = 16'h0100;
      check_outs("t6a");

      set_all(16'h0200);
      inputs_ready = 1'b1;
      tick();
      inputs_ready = 1'b0;
      for (int m = 1; m <= 30; m++) begin
         tick();
         if (m == 10) check("t6_hold_group0", out_none[0], 16'h0100);
         if (m == 30) begin
            check("t6_group0_none", out_none[0], 16'h0200);
            check("t6_group0_relu", out_relu[0], 16'h0200);
            check("t6_midrun_busy", 16'({busy_none, busy_relu, rdy_none, rdy_relu}), 16'hC);
         end
      end
      reset = 1'b0;
      #1;
      check("t6_reset_flags", 16'({busy_none, busy_relu, rdy_none, rdy_relu}), 16'h0);
      set_expect(16'h0000, 16'h0000);
      check_outs("t6_reset");
      tick();
      reset = 1'b1;
      set_all(16'h0100);
      run_wait("t6c", -1, -1);
      check_outs("t6c");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
